regfile_onehot_wr: RTL and testbench

- 32-entry by 64-bit register file; the stage directly downstream of the 5-to-32 write-address decoder.
- Writes are selected by the decoder's 32-bit one-hot enable vector, not by a binary address.
- Provides two combinational read ports with same-cycle write forwarding.
- Register 31 is hardwired to zero (XZR). Illegal select vectors are detected, and a sticky error flag is raised.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_cell.sv | 34 +++
 rtl/regfile_onehot_wr.sv | 91 +++++++++
 tb/tb_regfile_onehot_wr.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the one-hot-written register file.
//   DATA_W   : register width
//   NUM_REGS : entry count (matches the write-address decoder output width)
//   ZERO_REG : index of the hardwired-zero register
//   ADDR_W   : read address width
//   WR_CNT_W : width of the saturating committed-write counter
//   is_onehot: legality of a write-select vector (exactly one bit set)
package regfile_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ZERO_REG = 31;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned WR_CNT_W = 16;

  function automatic logic is_onehot(input logic [NUM_REGS-1:0] v);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (v[i]) ones++;
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/regfile_cell.sv
// Single storage word of the register file.
//   clk_i   : rising-edge clock
//   rst_ni  : asynchronous active-low reset, clears the word
//   we_i    : write enable
//   d_i     : write data
//   q_o     : stored value
module regfile_cell
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (we_i) data_d = d_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) data_q <= '0;
    else         data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/regfile_onehot_wr.sv
// 32 x 64 register file written through a one-hot select vector.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   wr_en    : global write strobe qualifying wr_sel
//   wr_sel   : one-hot write select from the address decoder
//   wr_data  : write data
//   rd_addr1 : read port 1 address
//   rd_addr2 : read port 2 address
//   rd_data1 : read port 1 data (combinational, forwards same-cycle write)
//   rd_data2 : read port 2 data (combinational, forwards same-cycle write)
//   sel_err  : sticky flag, set when wr_en=1 with a non-one-hot wr_sel
//   wr_count : saturating count of committed legal writes
module regfile_onehot_wr
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [NUM_REGS-1:0] wr_sel,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  output logic                sel_err,
  output logic [WR_CNT_W-1:0] wr_count
);

  localparam int unsigned RD_DEPTH = 2 ** ADDR_W;

  logic                sel_legal;
  logic                wr_commit;
  logic                sel_err_q;
  logic                sel_err_d;
  logic [WR_CNT_W-1:0] wr_count_q;
  logic [WR_CNT_W-1:0] wr_count_d;

  // Read table spans the full address space; entries with no backing cell
  // (the zero register and any index beyond NUM_REGS) read as zero, so the
  // read mux never sees an undriven input.
  logic [DATA_W-1:0]   rd_table [RD_DEPTH];
  logic [RD_DEPTH-1:0] fwd_hit;

  assign sel_legal = is_onehot(wr_sel);
  assign wr_commit = wr_en & sel_legal;

  for (genvar g = 0; g < RD_DEPTH; g++) begin : g_reg
    if (g < NUM_REGS && g != ZERO_REG) begin : g_cell
      regfile_cell #(
        .WIDTH (DATA_W)
      ) u_cell (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .we_i   (wr_commit & wr_sel[g]),
        .d_i    (wr_data),
        .q_o    (rd_table[g])
      );
      assign fwd_hit[g] = wr_commit & wr_sel[g];
    end else begin : g_zero
      assign rd_table[g] = '0;
      assign fwd_hit[g]  = 1'b0;
    end
  end

  always_comb begin
    rd_data1 = rd_table[rd_addr1];
    rd_data2 = rd_table[rd_addr2];
    if (fwd_hit[rd_addr1]) rd_data1 = wr_data;
    if (fwd_hit[rd_addr2]) rd_data2 = wr_data;
  end

  always_comb begin
    sel_err_d  = sel_err_q | (wr_en & ~sel_legal);
    wr_count_d = wr_count_q;
    if (wr_commit && wr_count_q != '1) wr_count_d = wr_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q  <= 1'b0;
      wr_count_q <= '0;
    end else begin
      sel_err_q  <= sel_err_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign sel_err  = sel_err_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
module tb_regfile_onehot_wr;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_sel;
  logic [63:0] wr_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [63:0] rd_data1;
  logic [63:0] rd_data2;
  logic        sel_err;
  logic [15:0] wr_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 0;

  regfile_onehot_wr dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .sel_err  (sel_err),
    .wr_count (wr_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents, error flag, counter.
  logic [63:0] m_regs [32];
  logic        m_err;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 64'h0;
      m_err <= 1'b0;
      m_cnt <= 0;
    end else if (wr_en) begin
      if ($countones(wr_sel) == 1) begin
        for (int i = 0; i < 31; i++)
          if (wr_sel[i]) m_regs[i] <= wr_data;
        m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end else begin
        m_err <= 1'b1;
      end
    end
  end

  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    int idx;
    idx = int'(a);
    if (idx == 31) return 64'h0;
    if (wr_en && $countones(wr_sel) == 1 && wr_sel[idx]) return wr_data;
    return m_regs[idx];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle when inputs are stable.
  always @(negedge clk) begin
    if (checking && rst_n) begin
      chk("model_rd1", rd_data1, exp_rd(rd_addr1));
      chk("model_rd2", rd_data2, exp_rd(rd_addr2));
      chk("model_err", {63'h0, sel_err}, {63'h0, m_err});
      chk("model_cnt", {48'h0, wr_count}, 64'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en   = 0;
    wr_sel  = 32'h0;
    wr_data = 64'h0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3 rst_n = 0;
    #1 chk("async_rst_err", {63'h0, sel_err}, 64'h0);
    chk("async_rst_cnt", {48'h0, wr_count}, 64'h0);
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    rst_n = 1; idle(); rd_addr1 = 0; rd_addr2 = 0;

    // Reset asserted mid-cycle while a write is being presented.
    @(posedge clk);
    #3 rst_n = 0;
    wr_en = 1; wr_sel = 32'h1; wr_data = 64'hFF;
    #1 chk("rst_err", {63'h0, sel_err}, 64'h0);
    chk("rst_cnt", {48'h0, wr_count}, 64'h0);
    @(posedge clk);
    #1 idle();
    rst_n = 1;
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(31 - i);
      #1;
      chk("rst_rd1", rd_data1, 64'h0);
      chk("rst_rd2", rd_data2, 64'h0);
    end
    checking = 1;

    // Legal write then read-back.
    step();
    wr_en = 1; wr_sel = 32'h0000_0020; wr_data = 64'hDEAD_BEEF_0000_0005; rd_addr1 = 5;
    step();
    idle();
    #1 chk("wr5_rd", rd_data1, 64'hDEAD_BEEF_0000_0005);
    chk("wr5_cnt", {48'h0, wr_count}, 64'd1);

    // Same-cycle forwarding on both ports.
    wr_en = 1; wr_sel = 32'h0000_0200; wr_data = 64'h1234; rd_addr1 = 9; rd_addr2 = 9;
    #1 chk("fwd_rd1", rd_data1, 64'h1234);
    chk("fwd_rd2", rd_data2, 64'h1234);
    step();
    idle();
    #1 chk("fwd_stored", rd_data1, 64'h1234);
    chk("fwd_cnt", {48'h0, wr_count}, 64'd2);

    // Zero register write is counted but never stored or forwarded.
    wr_en = 1; wr_sel = 32'h8000_0000; wr_data = 64'hFFFF_FFFF_FFFF_FFFF; rd_addr1 = 31;
    #1 chk("zr_same", rd_data1, 64'h0);
    step();
    idle();
    #1 chk("zr_next", rd_data1, 64'h0);
    chk("zr_cnt", {48'h0, wr_count}, 64'd3);

    // Illegal multi-hot select.
    wr_en = 1; wr_sel = 32'h0000_0003; wr_data = 64'hAA; rd_addr1 = 0; rd_addr2 = 1;
    #1 chk("ill_nofwd", rd_data1, 64'h0);
    step();
    idle();
    #1 chk("ill_r0", rd_data1, 64'h0);
    chk("ill_r1", rd_data2, 64'h0);
    chk("ill_err", {63'h0, sel_err}, 64'h1);
    chk("ill_cnt", {48'h0, wr_count}, 64'd3);

    // Legal write after an error still commits; flag is sticky.
    wr_en = 1; wr_sel = 32'h0000_0004; wr_data = 64'h77; rd_addr1 = 2;
    step();
    idle();
    #1 chk("post_ill_rd", rd_data1, 64'h77);
    chk("post_ill_err", {63'h0, sel_err}, 64'h1);
    chk("post_ill_cnt", {48'h0, wr_count}, 64'd4);

    // Zero-hot select also flags an error.
    pulse_reset();
    rd_addr1 = 5;
    #1 chk("rst2_r5", rd_data1, 64'h0);
    wr_en = 1; wr_sel = 32'h0; wr_data = 64'h55;
    step();
    idle();
    #1 chk("zh_err", {63'h0, sel_err}, 64'h1);
    chk("zh_cnt", {48'h0, wr_count}, 64'd0);

    // Disabled write with an illegal select is fully ignored.
    pulse_reset();
    wr_en = 0; wr_sel = 32'h3; wr_data = 64'h99; rd_addr1 = 0; rd_addr2 = 1;
    step();
    idle();
    #1 chk("dis_err", {63'h0, sel_err}, 64'h0);
    chk("dis_r0", rd_data1, 64'h0);
    chk("dis_r1", rd_data2, 64'h0);
    chk("dis_cnt", {48'h0, wr_count}, 64'd0);

    // Counter saturation.
    rd_addr1 = 3; rd_addr2 = 30;
    for (int i = 0; i < 65535; i++) begin
      wr_en = 1; wr_sel = 32'(1) << (i % 32); wr_data = 64'(i);
      step();
    end
    idle();
    #1 chk("sat_reach", {48'h0, wr_count}, 64'hFFFF);
    // i = 65507 was the last write to reg 3 (65507 % 32 == 3); 65534 to reg 30.
    chk("sat_r3", rd_data1, 64'd65507);
    chk("sat_r30", rd_data2, 64'd65534);
    wr_en = 1; wr_sel = 32'h0000_0010; wr_data = 64'h4;
    step();
    idle();
    #1 chk("sat_hold", {48'h0, wr_count}, 64'hFFFF);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
